// File: rtl/countdown_timer_n_pkg.sv
// Shared types and helpers for the countdown timer: FSM state encoding and load clamping.
package countdown_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // 32-bit arithmetic keeps MAX = 2**WIDTH representable for any WIDTH up to 31.
    function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] max_v);
        logic [31:0] top_v;
        top_v = max_v - 32'd1;
        if (val > top_v) begin
            clamp_load = top_v;
        end else begin
            clamp_load = val;
        end
    endfunction

endpackage

// File: rtl/countdown_timer_n_if.sv
// Control/status bundle for countdown_timer_n; the master drives commands, the slave is the timer.
interface countdown_timer_n_if #(
    parameter int WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             auto_reload;
    logic             en;
    logic             abort;
    logic [WIDTH-1:0] count_val;
    logic             busy;
    logic             tc;

    modport master (
        output start, load_val, auto_reload, en, abort,
        input  count_val, busy, tc
    );

    modport slave (
        input  start, load_val, auto_reload, en, abort,
        output count_val, busy, tc
    );

endinterface

// File: rtl/countdown_timer_n_prescale_tick.sv
// Free-running clock divider: one-cycle tick every PRESCALE cycles, restarted by a synchronous clear.
module prescale_tick #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(PRESCALE - 1));

    // Next divider value: clear restarts the phase so the first tick lands PRESCALE cycles later.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CW{1'b0}};
        end else if (tick) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Divider register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer_n.sv
// Programmable mod-MAX down counter with one-shot/auto-reload and one-cycle terminal-count pulse.
// Optional build macro COUNTDOWN_PRESCALE_EN slows counting to one step per PRESCALE clocks.
module countdown_timer_n
    import countdown_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MAX   = 200
`ifdef COUNTDOWN_PRESCALE_EN
    ,
    parameter int PRESCALE = 4
`endif
) (
    input logic              clk,
    input logic              rst_n,
    countdown_timer_n_if.slave bus
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] ld_s;
    logic             tick_s;

    assign ld_s = WIDTH'(clamp_load(32'(bus.load_val), 32'(MAX)));

`ifdef COUNTDOWN_PRESCALE_EN
    prescale_tick #(
        .PRESCALE(PRESCALE)
    ) u_prescale_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (bus.start | bus.abort),
        .tick (tick_s)
    );
`else
    assign tick_s = 1'b1;
`endif

    // Next-state logic: abort beats start, start beats counting; tc is zero unless a terminal step fires.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
            count_d = ZERO_C;
        end else if (bus.start) begin
            state_d  = RUN;
            count_d  = ld_s;
            reload_d = ld_s;
            mode_d   = bus.auto_reload;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.en && tick_s) begin
                        if (count_q != ZERO_C) begin
                            count_d = count_q - ONE_C;
                        end else begin
                            tc_d = 1'b1;
                            if (mode_q) begin
                                count_d = reload_q;
                            end else begin
                                state_d = IDLE;
                                count_d = ZERO_C;
                            end
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                IDLE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    count_d = ZERO_C;
                end
            endcase
        end
    end

    // State, count, reload and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= ZERO_C;
            reload_q <= ZERO_C;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tc_q     <= tc_d;
        end
    end

    assign bus.count_val = count_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.tc        = tc_q;

endmodule

// File: tb/tb_countdown_timer_n.sv
// Directed self-checking bench for countdown_timer_n (WIDTH=8, MAX=200; PRESCALE=4 when COUNTDOWN_PRESCALE_EN).
module tb_countdown_timer_n;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    countdown_timer_n_if #(.WIDTH(8)) bus ();

`ifdef COUNTDOWN_PRESCALE_EN
    countdown_timer_n #(.WIDTH(8), .MAX(200), .PRESCALE(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
`else
    countdown_timer_n #(.WIDTH(8), .MAX(200)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int cnt, input int bsy, input int t);
        check({tag, ".count"}, 32'(bus.count_val), 32'(cnt));
        check({tag, ".busy"},  32'(bus.busy),      32'(bsy));
        check({tag, ".tc"},    32'(bus.tc),        32'(t));
    endtask

    task automatic do_start(input int val, input logic ar);
        bus.start       = 1'b1;
        bus.load_val    = 8'(val);
        bus.auto_reload = ar;
        step(1);
        bus.start = 1'b0;
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.load_val    = 8'd0;
        bus.auto_reload = 1'b0;
        bus.en          = 1'b0;
        bus.abort       = 1'b0;
        step(2);
        check_all("reset", 0, 0, 0);
        rst_n = 1'b1;
        step(1);
        check_all("idle_after_reset", 0, 0, 0);

`ifdef COUNTDOWN_PRESCALE_EN
        // Prescaled: load 2, count moves at edges 4 and 8, tc at edge 12.
        bus.en = 1'b1;
        do_start(2, 1'b0);
        check_all("ps.load", 2, 1, 0);
        step(3);
        check_all("ps.hold1", 2, 1, 0);
        step(1);
        check_all("ps.c1", 1, 1, 0);
        step(3);
        check_all("ps.hold2", 1, 1, 0);
        step(1);
        check_all("ps.c0", 0, 1, 0);
        step(3);
        check_all("ps.hold3", 0, 1, 0);
        step(1);
        check_all("ps.tc", 0, 0, 1);
        step(1);
        check_all("ps.after", 0, 0, 0);
`else
        // One-shot load 5: 5..0 then tc on the sixth edge after start.
        bus.en = 1'b1;
        do_start(5, 1'b0);
        check_all("os.load", 5, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            step(1);
            check_all("os.run", 5 - i, 1, 0);
        end
        step(1);
        check_all("os.tc", 0, 0, 1);
        step(1);
        check_all("os.after", 0, 0, 0);

        // Asynchronous reset mid-count.
        do_start(10, 1'b0);
        check_all("rm.load", 10, 1, 0);
        step(4);
        check_all("rm.six", 6, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("rm.async", 0, 0, 0);
        step(1);
        rst_n = 1'b1;
        step(2);
        check_all("rm.quiet", 0, 0, 0);

        // Auto-reload with clamp: 250 -> 199, tc every 200 cycles.
        do_start(250, 1'b1);
        check_all("ar.load", 199, 1, 0);
        for (int p = 0; p < 3; p++) begin
            step(199);
            check_all("ar.zero", 0, 1, 0);
            step(1);
            check_all("ar.tc", 199, 1, 1);
        end
        step(1);
        check_all("ar.next", 198, 1, 0);
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;
        check_all("ar.abort", 0, 0, 0);

        // Clamp boundaries.
        do_start(200, 1'b0);
        check_all("clamp.200", 199, 1, 0);
        do_start(199, 1'b0);
        check_all("clamp.199", 199, 1, 0);
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;

        // Enable gating: load 3, en alternating 0/1, tc after four enabled cycles.
        do_start(3, 1'b0);
        check_all("en.load", 3, 1, 0);
        for (int i = 0; i < 4; i++) begin
            bus.en = 1'b0;
            step(1);
            check_all("en.hold", 3 - i, 1, 0);
            bus.en = 1'b1;
            step(1);
            if (i == 3) begin
                check_all("en.tc", 0, 0, 1);
            end else begin
                check_all("en.step", 2 - i, 1, 0);
            end
        end

        // N=0 auto-reload: tc every enabled cycle.
        do_start(0, 1'b1);
        check_all("n0.load", 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check_all("n0.tc", 0, 1, 1);
        end

        // abort together with start while count is 0: abort wins, no tc.
        bus.abort    = 1'b1;
        bus.start    = 1'b1;
        bus.load_val = 8'd9;
        step(1);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check_all("pri.abort", 0, 0, 0);
        step(1);
        check_all("pri.idle", 0, 0, 0);

        // Restart during RUN at count 2 with load 7: no tc.
        do_start(5, 1'b0);
        step(3);
        check_all("pri.at2", 2, 1, 0);
        do_start(7, 1'b0);
        check_all("pri.restart", 7, 1, 0);
        step(1);
        check_all("pri.cont", 6, 1, 0);
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;
        check_all("pri.end", 0, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
